// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle of the hazard scoreboard: ID instruction fields, stage results,
// and the stall/bypass decisions returned to the pipeline.
interface hazard_scoreboard_if #(
    parameter int WIDTH = 16,
    parameter int RSEL  = 3,
    parameter int DEPTH = 3
);
    logic                     id_valid;
    logic [RSEL-1:0]          id_rs1;
    logic                     id_rs1_used;
    logic [RSEL-1:0]          id_rs2;
    logic                     id_rs2_used;
    logic                     id_wr;
    logic [RSEL-1:0]          id_ws;
    logic                     id_is_load;
    logic                     flush;
    logic                     stat_clr;
    logic [DEPTH*WIDTH-1:0]   stage_data;
    logic                     stall;
    logic                     fwd1_hit;
    logic [WIDTH-1:0]         fwd1_data;
    logic                     fwd2_hit;
    logic [WIDTH-1:0]         fwd2_data;
    logic [(1<<RSEL)-1:0]     pend_mask;
    logic [15:0]              stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used,
               id_wr, id_ws, id_is_load, flush, stat_clr, stage_data,
        input  stall, fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, pend_mask, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used,
               id_wr, id_ws, id_is_load, flush, stat_clr, stage_data,
        output stall, fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, pend_mask, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding unit: tracks in-flight register writes EX..WB and decides per
// decode cycle whether to stall, bypass from a ready stage, or proceed.
module hazard_scoreboard #(
    parameter int WIDTH      = 16,
    parameter int RSEL       = 3,
    parameter int DEPTH      = 3,
    parameter int FWD_EN     = 1,
    parameter int ALU_READY  = 0,
    parameter int LOAD_READY = 1
) (
    input  logic               clk,
    input  logic               rst,
    hazard_scoreboard_if.slave bus
);
    localparam int NREGS = 1 << RSEL;

    logic [DEPTH-1:0]     r_v;
    logic [DEPTH-1:0]     r_ld;
    logic [RSEL-1:0]      r_ws [DEPTH];
    logic [15:0]          r_stall_cnt;

    logic [DEPTH-1:0]     w_ready;
    logic [1:0][RSEL-1:0] w_rs;
    logic [1:0]           w_used;
    logic [1:0]           w_haz;
    logic [1:0]           w_hit;
    logic [1:0][WIDTH-1:0] w_fdata;
    logic                 w_stall;
    logic                 w_insert;
    logic [NREGS-1:0]     w_pend;

    assign w_rs[0]   = bus.id_rs1;
    assign w_rs[1]   = bus.id_rs2;
    assign w_used[0] = bus.id_rs1_used;
    assign w_used[1] = bus.id_rs2_used;

    always_comb begin
        w_ready = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_ready[k] = (k >= (r_ld[k] ? LOAD_READY : ALU_READY));
        end
    end

    // Oldest stage is visited first so a younger match overwrites it.
    always_comb begin
        w_haz   = '0;
        w_hit   = '0;
        w_fdata = '0;
        for (int s = 0; s < 2; s++) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (r_v[k] && (r_ws[k] == w_rs[s]) && w_used[s] && bus.id_valid) begin
                    if ((FWD_EN != 0) && w_ready[k]) begin
                        w_hit[s]   = 1'b1;
                        w_haz[s]   = 1'b0;
                        w_fdata[s] = bus.stage_data[k*WIDTH +: WIDTH];
                    end else begin
                        w_hit[s]   = 1'b0;
                        w_haz[s]   = 1'b1;
                        w_fdata[s] = '0;
                    end
                end
            end
        end
    end

    always_comb begin
        w_pend = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (r_v[k]) begin
                w_pend[r_ws[k]] = 1'b1;
            end
        end
    end

    assign w_stall  = (|w_haz) & ~bus.flush;
    assign w_insert = bus.id_valid & bus.id_wr & ~w_stall & ~bus.flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v <= '0;
        end else begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                r_v[k] <= r_v[k-1];
            end
            r_v[0] <= w_insert;
        end
    end

    // NOTE: destination/load tags are qualified by r_v everywhere, so they carry no
    // reset; only the valid bits must be cleared.
    always_ff @(posedge clk) begin
        for (int k = DEPTH - 1; k > 0; k--) begin
            r_ws[k] <= r_ws[k-1];
            r_ld[k] <= r_ld[k-1];
        end
        r_ws[0] <= bus.id_ws;
        r_ld[0] <= bus.id_is_load;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (bus.stat_clr) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign bus.stall     = w_stall;
    assign bus.fwd1_hit  = w_hit[0];
    assign bus.fwd1_data = w_fdata[0];
    assign bus.fwd2_hit  = w_hit[1];
    assign bus.fwd2_data = w_fdata[1];
    assign bus.pend_mask = w_pend;
    assign bus.stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: bypass, stall-only and saturation configurations.
module tb_hazard_scoreboard;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    hazard_scoreboard_if #(.WIDTH(16), .RSEL(3), .DEPTH(3)) if_fwd ();
    hazard_scoreboard_if #(.WIDTH(16), .RSEL(3), .DEPTH(3)) if_nf ();
    hazard_scoreboard_if #(.WIDTH(16), .RSEL(3), .DEPTH(8)) if_sat ();

    hazard_scoreboard #(.WIDTH(16), .RSEL(3), .DEPTH(3), .FWD_EN(1)) u_fwd (
        .clk(clk), .rst(rst), .bus(if_fwd)
    );
    hazard_scoreboard #(.WIDTH(16), .RSEL(3), .DEPTH(3), .FWD_EN(0)) u_nf (
        .clk(clk), .rst(rst), .bus(if_nf)
    );
    hazard_scoreboard #(.WIDTH(16), .RSEL(3), .DEPTH(8), .FWD_EN(0)) u_sat (
        .clk(clk), .rst(rst), .bus(if_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [2:0]  rs1;
        logic        u1;
        logic [2:0]  rs2;
        logic        u2;
        logic        wr;
        logic [2:0]  ws;
        logic        ld;
        logic        flush;
        logic [47:0] sdata;
        logic        e_stall;
        logic        e_h1;
        logic [15:0] e_d1;
        logic        e_h2;
        logic [15:0] e_d2;
        logic [7:0]  e_pend;
    } vec_t;

    localparam logic [47:0] SD = 48'h9ABC_5678_1234;
    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_fwd(input vec_t v);
        if_fwd.id_valid    = v.valid;
        if_fwd.id_rs1      = v.rs1;
        if_fwd.id_rs1_used = v.u1;
        if_fwd.id_rs2      = v.rs2;
        if_fwd.id_rs2_used = v.u2;
        if_fwd.id_wr       = v.wr;
        if_fwd.id_ws       = v.ws;
        if_fwd.id_is_load  = v.ld;
        if_fwd.flush       = v.flush;
        if_fwd.stage_data  = v.sdata;
    endtask

    task automatic idle_fwd();
        if_fwd.id_valid = 1'b0; if_fwd.id_rs1 = '0; if_fwd.id_rs1_used = 1'b0;
        if_fwd.id_rs2 = '0; if_fwd.id_rs2_used = 1'b0; if_fwd.id_wr = 1'b0;
        if_fwd.id_ws = '0; if_fwd.id_is_load = 1'b0; if_fwd.flush = 1'b0;
        if_fwd.stat_clr = 1'b0; if_fwd.stage_data = SD;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        idle_fwd();
        if_nf.id_valid = 1'b0; if_nf.id_rs1 = '0; if_nf.id_rs1_used = 1'b0;
        if_nf.id_rs2 = '0; if_nf.id_rs2_used = 1'b0; if_nf.id_wr = 1'b0;
        if_nf.id_ws = '0; if_nf.id_is_load = 1'b0; if_nf.flush = 1'b0;
        if_nf.stat_clr = 1'b0; if_nf.stage_data = 48'hFFFF_EEEE_DDDD;
        if_sat.id_valid = 1'b0; if_sat.id_rs1 = '0; if_sat.id_rs1_used = 1'b0;
        if_sat.id_rs2 = '0; if_sat.id_rs2_used = 1'b0; if_sat.id_wr = 1'b0;
        if_sat.id_ws = '0; if_sat.id_is_load = 1'b0; if_sat.flush = 1'b0;
        if_sat.stat_clr = 1'b0; if_sat.stage_data = '0;

        //          valid rs1 u1 rs2 u2 wr ws ld fl sdata  stall h1 d1 h2 d2 pend
        vecs[0]  = '{1, 0, 0, 0, 0, 1, 3, 0, 0, SD, 0, 0, 16'h0000, 0, 16'h0000, 8'h00};
        vecs[1]  = '{1, 3, 1, 0, 0, 0, 0, 0, 0, SD, 0, 1, 16'h1234, 0, 16'h0000, 8'h08};
        vecs[2]  = '{1, 3, 1, 0, 0, 1, 2, 1, 0, SD, 0, 1, 16'h5678, 0, 16'h0000, 8'h08};
        vecs[3]  = '{1, 0, 0, 2, 1, 0, 0, 0, 0, SD, 1, 0, 16'h0000, 0, 16'h0000, 8'h0C};
        vecs[4]  = '{1, 0, 0, 2, 1, 0, 0, 0, 0, SD, 0, 0, 16'h0000, 1, 16'h5678, 8'h04};
        vecs[5]  = '{1, 2, 1, 2, 1, 1, 5, 0, 0, SD, 0, 1, 16'h9ABC, 1, 16'h9ABC, 8'h04};
        vecs[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, SD, 0, 0, 16'h0000, 0, 16'h0000, 8'h20};
        vecs[7]  = '{1, 0, 0, 0, 0, 1, 5, 0, 0, SD, 0, 0, 16'h0000, 0, 16'h0000, 8'h20};
        vecs[8]  = '{1, 5, 1, 0, 0, 1, 4, 1, 0, 48'hAAAA_5678_5555,
                     0, 1, 16'h5555, 0, 16'h0000, 8'h20};
        vecs[9]  = '{1, 4, 1, 0, 0, 1, 7, 0, 1, SD, 0, 0, 16'h0000, 0, 16'h0000, 8'h30};
        vecs[10] = '{0, 4, 1, 0, 0, 0, 0, 0, 0, SD, 0, 0, 16'h0000, 0, 16'h0000, 8'h30};
        vecs[11] = '{1, 4, 0, 4, 1, 0, 0, 0, 0, SD, 0, 0, 16'h0000, 1, 16'h9ABC, 8'h10};
        vecs[12] = '{1, 3, 1, 0, 0, 1, 3, 0, 0, SD, 0, 0, 16'h0000, 0, 16'h0000, 8'h00};
        vecs[13] = '{1, 3, 1, 3, 1, 1, 3, 0, 0, SD, 0, 1, 16'h1234, 1, 16'h1234, 8'h08};
        vecs[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, SD, 0, 0, 16'h0000, 0, 16'h0000, 8'h08};
        vecs[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, SD, 0, 0, 16'h0000, 0, 16'h0000, 8'h08};

        #12;
        rst = 1'b1;
        next_cycle();

        check("reset_pend", 32'(if_fwd.pend_mask), 32'h0);
        check("reset_stall", 32'(if_fwd.stall), 32'h0);
        check("reset_fwd1", 32'({if_fwd.fwd1_hit, if_fwd.fwd1_data}), 32'h0);
        check("reset_fwd2", 32'({if_fwd.fwd2_hit, if_fwd.fwd2_data}), 32'h0);
        check("reset_cnt", 32'(if_fwd.stall_cnt), 32'h0);

        for (int i = 0; i < NVEC; i++) begin
            drive_fwd(vecs[i]);
            #1;
            check($sformatf("v%0d_stall", i), 32'(if_fwd.stall), 32'(vecs[i].e_stall));
            check($sformatf("v%0d_h1", i), 32'(if_fwd.fwd1_hit), 32'(vecs[i].e_h1));
            check($sformatf("v%0d_d1", i), 32'(if_fwd.fwd1_data), 32'(vecs[i].e_d1));
            check($sformatf("v%0d_h2", i), 32'(if_fwd.fwd2_hit), 32'(vecs[i].e_h2));
            check($sformatf("v%0d_d2", i), 32'(if_fwd.fwd2_data), 32'(vecs[i].e_d2));
            check($sformatf("v%0d_pend", i), 32'(if_fwd.pend_mask), 32'(vecs[i].e_pend));
            next_cycle();
        end
        check("table_stall_cnt", 32'(if_fwd.stall_cnt), 32'd1);

        idle_fwd();
        repeat (3) next_cycle();
        check("drained_pend", 32'(if_fwd.pend_mask), 32'h0);

        // Fill the pipe, take a load-use stall, then drop reset mid-cycle.
        if_fwd.id_valid = 1'b1; if_fwd.id_wr = 1'b1; if_fwd.id_ws = 3'd1;
        next_cycle();
        if_fwd.id_ws = 3'd2;
        next_cycle();
        if_fwd.id_ws = 3'd3; if_fwd.id_is_load = 1'b1;
        next_cycle();
        if_fwd.id_wr = 1'b0; if_fwd.id_is_load = 1'b0;
        if_fwd.id_rs1 = 3'd3; if_fwd.id_rs1_used = 1'b1;
        #1;
        check("full_stall", 32'(if_fwd.stall), 32'h1);
        check("full_pend", 32'(if_fwd.pend_mask), 32'h0E);
        next_cycle();
        check("after_stall_hit", 32'({if_fwd.fwd1_hit, if_fwd.fwd1_data}), 32'h1_5678);
        check("after_stall_cnt", 32'(if_fwd.stall_cnt), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_pend", 32'(if_fwd.pend_mask), 32'h0);
        check("midrst_stall", 32'(if_fwd.stall), 32'h0);
        check("midrst_hit", 32'(if_fwd.fwd1_hit), 32'h0);
        check("midrst_cnt", 32'(if_fwd.stall_cnt), 32'h0);
        #1;
        rst = 1'b1;
        idle_fwd();
        next_cycle();

        // stat_clr takes priority over a concurrent stall.
        if_fwd.id_valid = 1'b1; if_fwd.id_wr = 1'b1; if_fwd.id_ws = 3'd6; if_fwd.id_is_load = 1'b1;
        next_cycle();
        if_fwd.id_wr = 1'b0; if_fwd.id_is_load = 1'b0;
        if_fwd.id_rs1 = 3'd6; if_fwd.id_rs1_used = 1'b1; if_fwd.stat_clr = 1'b1;
        #1;
        check("clr_stall", 32'(if_fwd.stall), 32'h1);
        next_cycle();
        if_fwd.stat_clr = 1'b0;
        #1;
        check("clr_cnt", 32'(if_fwd.stall_cnt), 32'h0);
        check("clr_fwd", 32'({if_fwd.fwd1_hit, if_fwd.fwd1_data}), 32'h1_5678);
        idle_fwd();

        // Stall-only mode: a single write holds a dependent read for DEPTH cycles.
        if_nf.id_valid = 1'b1; if_nf.id_wr = 1'b1; if_nf.id_ws = 3'd1;
        next_cycle();
        if_nf.id_wr = 1'b0; if_nf.id_rs1 = 3'd1; if_nf.id_rs1_used = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("nf_stall_c%0d", c), 32'(if_nf.stall), (c < 3) ? 32'h1 : 32'h0);
            check($sformatf("nf_fwd_c%0d", c), 32'({if_nf.fwd1_hit, if_nf.fwd1_data}), 32'h0);
            check($sformatf("nf_pend_c%0d", c), 32'(if_nf.pend_mask), (c < 3) ? 32'h02 : 32'h0);
            next_cycle();
        end
        check("nf_cnt", 32'(if_nf.stall_cnt), 32'd3);
        if_nf.id_valid = 1'b0; if_nf.id_rs1_used = 1'b0;

        // Saturation: back-to-back self-dependent writes stall 8 of every 9 cycles.
        if_sat.id_valid = 1'b1; if_sat.id_wr = 1'b1; if_sat.id_ws = 3'd1;
        if_sat.id_rs1 = 3'd1; if_sat.id_rs1_used = 1'b1;
        repeat (73726) @(posedge clk);
        #1;
        check("sat_fffe", 32'(if_sat.stall_cnt), 32'hFFFE);
        check("sat_stalling", 32'(if_sat.stall), 32'h1);
        next_cycle();
        check("sat_ffff", 32'(if_sat.stall_cnt), 32'hFFFF);
        repeat (3) next_cycle();
        check("sat_hold", 32'(if_sat.stall_cnt), 32'hFFFF);
        if_sat.id_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
